proc_sequencer: RTL and testbench

Multi-cycle control sequencer for the 32-bit single-core processor datapath. Owns the program counter and instruction register and walks each instruction through IDLE/FETCH/DECODE/EXECUTE/MEM/WB. It drives the program ROM address, register-file read/write strobes, ALU opcode and a req/ack data-memory handshake. It replaces ad-hoc per-stage flag sequencing with one explicit state machine.

---
 rtl/proc_sequencer_if.sv | 33 +++
 rtl/proc_sequencer.sv | 144 ++++++++++++++
 tb/tb_proc_sequencer.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/proc_sequencer_if.sv
// Memory-side bundle of the instruction sequencer.
//   imem_addr / imem_data : program ROM address out, combinational instruction back
//   dmem_req / dmem_we / dmem_addr / dmem_ack : data-memory req/ack handshake
// master = sequencer side, slave = memory side.
interface proc_sequencer_if #(
  parameter int unsigned PcW = 5,
  parameter int unsigned IrW = 32
);
  logic [PcW-1:0] imem_addr;
  logic [IrW-1:0] imem_data;
  logic           dmem_req;
  logic           dmem_we;
  logic [4:0]     dmem_addr;
  logic           dmem_ack;

  modport master (
    output imem_addr,
    input  imem_data,
    output dmem_req,
    output dmem_we,
    output dmem_addr,
    input  dmem_ack
  );

  modport slave (
    input  imem_addr,
    output imem_data,
    input  dmem_req,
    input  dmem_we,
    input  dmem_addr,
    output dmem_ack
  );
endinterface

// File: rtl/proc_sequencer.sv
// Multi-cycle control sequencer: owns pc and ir and steps each instruction through
// IDLE/FETCH/DECODE/EXECUTE/MEM/WB, parking in HALT on the halt opcode.
// Ports:
//   clk_i, rst_ni        : clock, asynchronous active-low reset
//   mem_io (master)      : program ROM fetch and data-memory req/ack handshake
//   run_i                : start/continue, looked at only in IDLE and on WB exit
//   ir_o + field outputs : latched instruction and its opcode/rdst/rsrc1/rsrc2 fields
//   rf_rd_en_o, rf_wr_en_o, rf_wr_sel_o, alu_op_o : datapath strobes
//   halted_o, state_o    : status
//   retired_cnt_o        : retired-instruction counter, present only when the
//                          SEQ_RETIRE_CNT_EN macro is defined
module proc_sequencer #(
  parameter int unsigned PcW = 5,
  parameter int unsigned IrW = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  proc_sequencer_if.master mem_io,
  input  logic             run_i,
  output logic [IrW-1:0]   ir_o,
  output logic [4:0]       opcode_o,
  output logic [4:0]       rdst_o,
  output logic [4:0]       rsrc1_o,
  output logic [4:0]       rsrc2_o,
  output logic             rf_rd_en_o,
  output logic             rf_wr_en_o,
  output logic             rf_wr_sel_o,
  output logic [4:0]       alu_op_o,
  output logic             halted_o,
  output logic [2:0]       state_o
`ifdef SEQ_RETIRE_CNT_EN
  ,
  output logic [15:0]      retired_cnt_o
`endif
);

  localparam logic [4:0] OpLoad  = 5'b10000;
  localparam logic [4:0] OpStore = 5'b10001;
  localparam logic [4:0] OpHalt  = 5'b11111;

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StFetch   = 3'd1,
    StDecode  = 3'd2,
    StExecute = 3'd3,
    StMem     = 3'd4,
    StWb      = 3'd5,
    StHalt    = 3'd6
  } state_e;

  state_e         state_q, state_d;
  logic [PcW-1:0] pc_q;
  logic [IrW-1:0] ir_q;
  logic           rf_rd_en_q, rf_wr_en_q, rf_wr_sel_q;
  logic [4:0]     alu_op_q;
  logic           dmem_req_q, dmem_we_q;
  logic [4:0]     dmem_addr_q;
  logic           halted_q;

  logic [4:0] opcode;
  logic       is_load, is_store, is_halt;

  assign opcode   = ir_q[31:27];
  assign is_load  = (opcode == OpLoad);
  assign is_store = (opcode == OpStore);
  assign is_halt  = (opcode == OpHalt);

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:    if (run_i) state_d = StFetch;
      StFetch:   state_d = StDecode;
      StDecode:  state_d = is_halt ? StHalt : StExecute;
      StExecute: state_d = (is_load || is_store) ? StMem : StWb;
      StMem:     if (mem_io.dmem_ack) state_d = StWb;
      StWb:      state_d = run_i ? StFetch : StIdle;
      StHalt:    state_d = StHalt;
      default:   state_d = StIdle;  // unused code 7 recovers to IDLE
    endcase
  end

  // Strobes are registered from the next state, so each one is valid for exactly the
  // cycles spent in its state. ir_q is already stable whenever an ir-derived strobe is
  // loaded (entering EXECUTE, MEM or WB).
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      pc_q        <= '0;
      ir_q        <= '0;
      rf_rd_en_q  <= 1'b0;
      rf_wr_en_q  <= 1'b0;
      rf_wr_sel_q <= 1'b0;
      alu_op_q    <= '0;
      dmem_req_q  <= 1'b0;
      dmem_we_q   <= 1'b0;
      dmem_addr_q <= '0;
      halted_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == StFetch) ir_q <= mem_io.imem_data;
      if (state_q == StWb)    pc_q <= pc_q + PcW'(1);  // wraps silently
      rf_rd_en_q  <= (state_d == StDecode) || (state_d == StExecute);
      alu_op_q    <= (state_d == StExecute) ? opcode : 5'd0;
      dmem_req_q  <= (state_d == StMem);
      dmem_we_q   <= (state_d == StMem) && is_store;
      dmem_addr_q <= (state_d == StMem) ? ir_q[4:0] : 5'd0;
      rf_wr_en_q  <= (state_d == StWb) && !is_store;
      rf_wr_sel_q <= (state_d == StWb) && is_load;
      halted_q    <= (state_d == StHalt);
    end
  end

`ifdef SEQ_RETIRE_CNT_EN
  logic [15:0] retired_cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      retired_cnt_q <= '0;
    end else if (state_q == StWb) begin
      retired_cnt_q <= retired_cnt_q + 16'd1;
    end
  end

  assign retired_cnt_o = retired_cnt_q;
`endif

  assign mem_io.imem_addr = pc_q;
  assign mem_io.dmem_req  = dmem_req_q;
  assign mem_io.dmem_we   = dmem_we_q;
  assign mem_io.dmem_addr = dmem_addr_q;

  assign ir_o        = ir_q;
  assign opcode_o    = opcode;
  assign rdst_o      = ir_q[26:22];
  assign rsrc1_o     = ir_q[4:0];
  assign rsrc2_o     = ir_q[9:5];
  assign rf_rd_en_o  = rf_rd_en_q;
  assign rf_wr_en_o  = rf_wr_en_q;
  assign rf_wr_sel_o = rf_wr_sel_q;
  assign alu_op_o    = alu_op_q;
  assign halted_o    = halted_q;
  assign state_o     = state_q;

endmodule

// File: tb/tb_proc_sequencer.sv
// Bench for proc_sequencer: a ROM array feeds the fetch port, the bench plays the data
// memory, and each instruction's expected cycle-by-cycle trace is derived from its opcode
// and the chosen ack delay.
module tb_proc_sequencer;

  logic clk = 1'b0;
  logic rst_n;
  logic run;

  proc_sequencer_if bus ();

  logic [31:0] rom [32];
  assign bus.imem_data = rom[bus.imem_addr];

  logic [31:0] ir;
  logic [4:0]  opcode, rdst, rsrc1, rsrc2, alu_op;
  logic        rf_rd_en, rf_wr_en, rf_wr_sel, halted;
  logic [2:0]  state;
`ifdef SEQ_RETIRE_CNT_EN
  logic [15:0] retired_cnt;
`endif

  proc_sequencer u_dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .mem_io      (bus),
    .run_i       (run),
    .ir_o        (ir),
    .opcode_o    (opcode),
    .rdst_o      (rdst),
    .rsrc1_o     (rsrc1),
    .rsrc2_o     (rsrc2),
    .rf_rd_en_o  (rf_rd_en),
    .rf_wr_en_o  (rf_wr_en),
    .rf_wr_sel_o (rf_wr_sel),
    .alu_op_o    (alu_op),
    .halted_o    (halted),
    .state_o     (state)
`ifdef SEQ_RETIRE_CNT_EN
    ,
    .retired_cnt_o (retired_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int m_pc    = 0;
  int m_retired = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_quiet(input string tag);
    check_eq({tag, "_state"}, 32'(state), 32'd0);
    check_eq({tag, "_pc"}, 32'(bus.imem_addr), 32'd0);
    check_eq({tag, "_ir"}, ir, 32'd0);
    check_eq({tag, "_rd"}, 32'(rf_rd_en), 32'd0);
    check_eq({tag, "_wr"}, 32'(rf_wr_en), 32'd0);
    check_eq({tag, "_wsel"}, 32'(rf_wr_sel), 32'd0);
    check_eq({tag, "_aluop"}, 32'(alu_op), 32'd0);
    check_eq({tag, "_req"}, 32'(bus.dmem_req), 32'd0);
    check_eq({tag, "_we"}, 32'(bus.dmem_we), 32'd0);
    check_eq({tag, "_daddr"}, 32'(bus.dmem_addr), 32'd0);
    check_eq({tag, "_halted"}, 32'(halted), 32'd0);
`ifdef SEQ_RETIRE_CNT_EN
    check_eq({tag, "_retired"}, 32'(retired_cnt), 32'd0);
`endif
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    run = 1'b0;
    bus.dmem_ack = 1'b0;
    m_pc = 0;
    m_retired = 0;
    #1;
    check_quiet("rst_async");
    step();
    check_quiet("rst");
    rst_n = 1'b1;
  endtask

  // Entered with the DUT sampled in FETCH. Walks one instruction to the cycle after WB.
  task automatic run_instr(input int ack_delay, input bit run_after);
    logic [31:0] ins;
    logic [4:0]  op;
    bit          is_ld, is_st;
    ins   = rom[m_pc];
    op    = ins[31:27];
    is_ld = (op == 5'b10000);
    is_st = (op == 5'b10001);

    check_eq("fetch_state", 32'(state), 32'd1);
    check_eq("fetch_addr", 32'(bus.imem_addr), 32'(m_pc));
    check_eq("fetch_wr", 32'(rf_wr_en), 32'd0);
    check_eq("fetch_req", 32'(bus.dmem_req), 32'd0);
    run = 1'($urandom);
    bus.dmem_ack = 1'($urandom);
    step();

    check_eq("dec_state", 32'(state), 32'd2);
    check_eq("dec_ir", ir, ins);
    check_eq("dec_opcode", 32'(opcode), 32'(op));
    check_eq("dec_rdst", 32'(rdst), 32'(ins[26:22]));
    check_eq("dec_rsrc1", 32'(rsrc1), 32'(ins[4:0]));
    check_eq("dec_rsrc2", 32'(rsrc2), 32'(ins[9:5]));
    check_eq("dec_rd", 32'(rf_rd_en), 32'd1);
    run = 1'($urandom);
    bus.dmem_ack = 1'($urandom);
    step();

    if (op == 5'b11111) begin
      check_eq("halt_state", 32'(state), 32'd6);
      check_eq("halt_flag", 32'(halted), 32'd1);
      check_eq("halt_rd", 32'(rf_rd_en), 32'd0);
      return;
    end

    check_eq("ex_state", 32'(state), 32'd3);
    check_eq("ex_aluop", 32'(alu_op), 32'(op));
    check_eq("ex_rd", 32'(rf_rd_en), 32'd1);
    check_eq("ex_req", 32'(bus.dmem_req), 32'd0);
    run = 1'($urandom);
    bus.dmem_ack = 1'($urandom);

    if (is_ld || is_st) begin
      for (int k = 0; k <= ack_delay; k++) begin
        step();
        check_eq("mem_state", 32'(state), 32'd4);
        check_eq("mem_req", 32'(bus.dmem_req), 32'd1);
        check_eq("mem_addr", 32'(bus.dmem_addr), 32'(ins[4:0]));
        check_eq("mem_we", 32'(bus.dmem_we), 32'(is_st));
        check_eq("mem_wr", 32'(rf_wr_en), 32'd0);
        run = 1'($urandom);
        bus.dmem_ack = (k == ack_delay);
      end
    end
    step();

    check_eq("wb_state", 32'(state), 32'd5);
    check_eq("wb_wr", 32'(rf_wr_en), 32'(!is_st));
    check_eq("wb_wsel", 32'(rf_wr_sel), 32'(is_ld));
    check_eq("wb_req", 32'(bus.dmem_req), 32'd0);
    check_eq("wb_aluop", 32'(alu_op), 32'd0);
    run = run_after;
    bus.dmem_ack = 1'($urandom);
    m_pc = (m_pc + 1) % 32;
    m_retired++;
    step();

    check_eq("post_state", 32'(state), run_after ? 32'd1 : 32'd0);
    check_eq("post_pc", 32'(bus.imem_addr), 32'(m_pc));
    check_eq("post_wr", 32'(rf_wr_en), 32'd0);
`ifdef SEQ_RETIRE_CNT_EN
    check_eq("post_retired", 32'(retired_cnt), 32'(16'(m_retired)));
`endif
  endtask

  initial begin
    rst_n = 1'b1;
    run = 1'b0;
    bus.dmem_ack = 1'b0;
    for (int i = 0; i < 32; i++) rom[i] = 32'd0;
    step();

    // Directed program: ALU, load with delayed ack, store, halt at ROM[3].
    rom[0] = {5'b00001, 5'd3, 12'd0, 5'd2, 5'd1};
    rom[1] = {5'b10000, 5'd4, 12'd0, 5'd0, 5'd7};
    rom[2] = {5'b10001, 5'd0, 12'd0, 5'd5, 5'd12};
    rom[3] = {5'b11111, 27'd0};
    do_reset();
    for (int i = 0; i < 2; i++) begin
      step();
      check_eq("idle_wait", 32'(state), 32'd0);
    end
    run = 1'b1;
    step();
    run_instr(0, 1'b1);
    run_instr(3, 1'b1);
    run_instr(0, 1'b0);
    step();
    check_eq("idle_hold", 32'(state), 32'd0);
    check_eq("idle_pc", 32'(bus.imem_addr), 32'd3);
    run = 1'b1;
    step();
    run_instr(0, 1'b1);
    for (int i = 0; i < 100; i++) begin
      run = 1'($urandom);
      bus.dmem_ack = 1'($urandom);
      step();
      check_eq("halt_hold", 32'(state), 32'd6);
      check_eq("halt_hold_flag", 32'(halted), 32'd1);
      check_eq("halt_hold_pc", 32'(bus.imem_addr), 32'd3);
    end

    // Random non-halt program, walked past the pc wrap.
    do_reset();
    for (int i = 0; i < 32; i++) rom[i] = {5'($urandom_range(30, 0)), 27'($urandom)};
    run = 1'b1;
    step();
    for (int i = 0; i < 32; i++) run_instr(int'($urandom_range(4, 0)), 1'b1);
    check_eq("wrap_pc", 32'(bus.imem_addr), 32'd0);
`ifdef SEQ_RETIRE_CNT_EN
    check_eq("retired_32", 32'(retired_cnt), 32'd32);
`endif
    for (int i = 0; i < 10; i++) begin
      bit ra;
      ra = 1'($urandom);
      run_instr(int'($urandom_range(4, 0)), ra);
      if (!ra) begin
        run = 1'b1;
        step();
      end
    end

    // Reset while waiting in MEM.
    do_reset();
    rom[0] = {5'b10000, 5'd1, 12'd0, 5'd0, 5'd9};
    run = 1'b1;
    for (int i = 0; i < 4; i++) step();
    check_eq("mw_state", 32'(state), 32'd4);
    check_eq("mw_req", 32'(bus.dmem_req), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("mw_req_drop", 32'(bus.dmem_req), 32'd0);
    check_quiet("mw_rst");
    step();
    check_quiet("mw_rst_hold");
    rst_n = 1'b1;
    run = 1'b0;
    step();
    check_eq("mw_idle", 32'(state), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
